// File: rtl/relay_alu_pkg.sv
// Shared types and defaults for the relay ALU sequencer and its helpers.
package relay_alu_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_INC = 3'b001,
    FN_AND = 3'b010,
    FN_OR  = 3'b011,
    FN_XOR = 3'b100,
    FN_NOT = 3'b101,
    FN_SHL = 3'b110,
    FN_CLR = 3'b111
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/relay_alu_flags.sv
// Condition flag derivation from a result word and its carry-out.
module relay_alu_flags #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  output logic             zero,
  output logic             sign,
  output logic             carry
);

  assign zero  = (result == '0);
  assign sign  = result[WIDTH-1];
  assign carry = carry_in;

endmodule

// File: rtl/relay_logic_sequencer.sv
// Drives operands onto the relay gate array, waits the settle time, latches result and flags.
// Optional macro GATE_CHECK_EN builds a sticky gate-array consistency checker (gate_err).
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_SETTLE | operands applied, counting down relay settle time
// ST_DONE   | result latched, res_valid pulse
module relay_logic_sequencer
  import relay_alu_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  output logic [WIDTH-1:0] b_drive,
  output logic [WIDTH-1:0] c_drive,
  input  logic [WIDTH-1:0] gate_and,
  input  logic [WIDTH-1:0] gate_or,
  input  logic [WIDTH-1:0] gate_xor,
  input  logic [WIDTH-1:0] gate_not,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             flag_zero,
  output logic             flag_sign,
  output logic             flag_carry,
  output logic             gate_err
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  alu_func_e        func_q;
  logic             accept, capture;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_nxt;
  logic [WIDTH:0]   sum;
  logic             zero_nxt, sign_nxt, cflag_nxt;

  assign accept  = (state == ST_IDLE) && op_valid;
  assign capture = (state == ST_SETTLE) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (op_valid) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state == ST_IDLE);
    res_valid = (state == ST_DONE);
  end

  // Logic functions come from the gate array; arithmetic and shift are local.
  always_comb begin
    res_nxt   = '0;
    carry_nxt = 1'b0;
    sum       = '0;
    case (func_q)
      FN_ADD: begin
        sum       = {1'b0, b_drive} + {1'b0, c_drive};
        res_nxt   = sum[WIDTH-1:0];
        carry_nxt = sum[WIDTH];
      end
      FN_INC: begin
        sum       = {1'b0, b_drive} + (WIDTH+1)'(1);
        res_nxt   = sum[WIDTH-1:0];
        carry_nxt = sum[WIDTH];
      end
      FN_AND:  res_nxt = gate_and;
      FN_OR:   res_nxt = gate_or;
      FN_XOR:  res_nxt = gate_xor;
      FN_NOT:  res_nxt = gate_not;
      FN_SHL:  res_nxt = {b_drive[WIDTH-2:0], b_drive[WIDTH-1]};
      default: res_nxt = '0;
    endcase
  end

  relay_alu_flags #(.WIDTH(WIDTH)) u_flags (
    .result   (res_nxt),
    .carry_in (carry_nxt),
    .zero     (zero_nxt),
    .sign     (sign_nxt),
    .carry    (cflag_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      b_drive    <= '0;
      c_drive    <= '0;
      func_q     <= FN_ADD;
      cnt        <= '0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_sign  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      if (accept) begin
        b_drive <= b_in;
        c_drive <= c_in;
        func_q  <= alu_func_e'(func);
        cnt     <= CW'(SETTLE_CYCLES - 1);
      end else if (state == ST_SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        result     <= res_nxt;
        flag_zero  <= zero_nxt;
        flag_sign  <= sign_nxt;
        flag_carry <= cflag_nxt;
      end
    end
  end

`ifdef GATE_CHECK_EN
  logic gate_mismatch;
  assign gate_mismatch = (gate_and != (b_drive & c_drive)) ||
                         (gate_or  != (b_drive | c_drive)) ||
                         (gate_xor != (b_drive ^ c_drive)) ||
                         (gate_not != ~b_drive);

  always_ff @(posedge clk) begin
    if (reset)                         gate_err <= 1'b0;
    else if (capture && gate_mismatch) gate_err <= 1'b1;
  end
`else
  assign gate_err = 1'b0;
`endif

endmodule

// File: doc/relay_logic_sequencer.md
Name: relay_logic_sequencer

Overview:
- Consumer/reader side of the bitwise universal-gate array.
- Accepts an ALU operation request, registers B/C operands and drives them onto the gate array, waits an emulated relay settle time, then latches the selected result and condition flags.
- Sits between the instruction sequencer and the per-bit gate blocks; arithmetic and shift functions are computed in-block.

Parameters:
- WIDTH, 8, operand/result width (one gate block per bit).
- SETTLE_CYCLES, 4, relay settle emulation in clocks; legal range >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  request strobe
- op_ready  out  1  high when able to accept a request
- func  in  3  000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 CLR
- b_in  in  WIDTH  B operand
- c_in  in  WIDTH  C operand
- b_drive  out  WIDTH  registered B applied to the gate array
- c_drive  out  WIDTH  registered C applied to the gate array
- gate_and, gate_or, gate_xor, gate_not  in  WIDTH each  gate array outputs
- result  out  WIDTH  latched result
- res_valid  out  1  one-cycle completion pulse
- flag_zero, flag_sign, flag_carry  out  1 each  condition flags
- gate_err  out  1  sticky gate mismatch; see Optional Feature

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, clock port clk, reset port reset.
- Reset values: all outputs 0 except op_ready = 1. State IDLE, settle counter 0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - op_ready = 1.
  - On op_valid & op_ready: register b_in→b_drive, c_in→c_drive and func; load counter = SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - op_ready = 0; b_drive/c_drive held stable.
  - Decrement the counter each cycle.
  - When counter == 0: capture result and flags, go to DONE.
- DONE:
  - res_valid = 1 for exactly one cycle; op_ready = 0; next state IDLE.
  - A new request is accepted no earlier than the cycle after DONE.
- Latency: accept at edge T; res_valid high during cycle T+SETTLE_CYCLES+1. Throughput is one op per SETTLE_CYCLES+2 cycles.
- Result selection:
  - AND, OR, XOR, NOT come from the gate_* lanes. NOT lanes reflect ~B per the gate contract.
  - ADD = b_drive + c_drive, WIDTH+1-bit sum; carry = MSB of the sum.
  - INC = b_drive + 1; carry = MSB of the sum.
  - SHL = {b_drive[WIDTH-2:0], b_drive[WIDTH-1]} (circular left shift); carry = 0.
  - CLR: result = 0.
- Flags:
  - zero = (result == 0); sign = result[WIDTH-1].
  - carry = 0 for all functions except ADD and INC.
  - Flags update only at capture and hold otherwise.
- result and flags hold until the next capture. res_valid does not gate their visibility.
- op_valid while not in IDLE: ignored. No queuing; the requester must hold op_valid until op_ready is seen.
- Wrap-around: ADD 0xFF+0x01 → result 0x00, carry 1, zero 1.
- Reset mid-operation (SETTLE or DONE):
  - Abort to IDLE; outputs return to reset values next edge.
  - No res_valid pulse for the aborted op.
- SETTLE_CYCLES = 1: capture occurs the cycle after accept.

Optional Feature:
- Macro: GATE_CHECK_EN.
- Defined:
  - At capture, compare gate_and/or/xor/not against an internal model of b_drive & c_drive, |, ^, ~b_drive.
  - Any mismatch sets gate_err; it is sticky and cleared only by reset.
  - Checked for all functions.
- Undefined: the comparator is not built; gate_err is tied 0. The port list is unchanged.

Decomposition:
- Package relay_alu_pkg:
  - alu_func_e enum (8 codes above).
  - seq_state_e enum (IDLE/SETTLE/DONE).
  - Default WIDTH and SETTLE_CYCLES constants.
- Sub-module relay_alu_flags: combinational result/carry → zero/sign/carry. Instantiated once; reused by the future accumulator block.

Test Plan (WIDTH=8, SETTLE_CYCLES=4, gate array model attached):
- Reset then idle → op_ready=1; result, flags, res_valid, gate_err all 0.
- AND, B=0xF0, C=0x3C, accept at T → b_drive/c_drive stable T+1..T+5; res_valid only in cycle T+5; result 0x30, zero 0, sign 0, carry 0.
- ADD, B=0xFF, C=0x01 → result 0x00, carry 1, zero 1; then INC, B=0x7F → 0x80, sign 1, carry 0.
- op_valid held high during SETTLE with a different func → ignored. Second op accepted only in the IDLE cycle after DONE; spacing between accepts = 6 cycles.
- Reset asserted in the 2nd SETTLE cycle → next edge IDLE with outputs at reset values; no res_valid; a fresh XOR 0xAA^0x55 then yields 0xFF, sign 1.
- GATE_CHECK_EN defined, gate_xor bit 0 forced stuck-0, XOR 0x01^0x00 → gate_err=1 at capture and remains 1 through later correct ops until reset. Undefined build: gate_err stays 0.
